// File: rtl/dff_bank_sched.sv
// Round-robin scheduler serialising load/set/reset/read accesses from NREQ clients onto a DEPTH x WIDTH register bank.
// Define DFF_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module dff_bank_sched #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int NREQ  = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int IW = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic [NREQ-1:0]        req,
  input  logic [2*NREQ-1:0]      op,
  input  logic [AW*NREQ-1:0]     addr,
  input  logic [WIDTH*NREQ-1:0]  wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        ack,
  output logic [WIDTH-1:0]       rdata,
  output logic                   busy,
  output logic [WIDTH*DEPTH-1:0] q
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLR   = 2'b10;

  logic [1:0]       op_arr    [NREQ];
  logic [AW-1:0]    addr_arr  [NREQ];
  logic [WIDTH-1:0] wdata_arr [NREQ];
  logic [WIDTH-1:0] bank_reg  [DEPTH];

  logic [1:0]       state_reg;
  logic [1:0]       op_reg;
  logic [AW-1:0]    addr_reg;
  logic [WIDTH-1:0] wdata_reg;
  logic [IW-1:0]    win_reg;
  logic [NREQ-1:0]  gnt_reg;
  logic [NREQ-1:0]  ack_reg;
  logic [WIDTH-1:0] rdata_reg;

  logic [IW-1:0]    win_next;
  logic             found_next;
  logic [WIDTH-1:0] post_next;
  logic             in_range;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req_slice
      assign op_arr[gi]    = op[2*gi +: 2];
      assign addr_arr[gi]  = addr[AW*gi +: AW];
      assign wdata_arr[gi] = wdata[WIDTH*gi +: WIDTH];
    end
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_q_flat
      assign q[WIDTH*gi +: WIDTH] = bank_reg[gi];
    end
  endgenerate

`ifdef DFF_SCHED_FIXED_PRIO_EN
  always_comb begin
    win_next   = '0;
    found_next = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found_next && req[i[IW-1:0]]) begin
        found_next = 1'b1;
        win_next   = i[IW-1:0];
      end
    end
  end
`else
  logic [IW-1:0] ptr_reg;
  int            scan_idx;

  // Scan starts just after the last winner so every requester gets a turn.
  always_comb begin
    win_next   = '0;
    found_next = 1'b0;
    scan_idx   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      scan_idx = (int'(ptr_reg) + i) % NREQ;
      if (!found_next && req[scan_idx[IW-1:0]]) begin
        found_next = 1'b1;
        win_next   = scan_idx[IW-1:0];
      end
    end
  end
`endif

  // Non-power-of-two banks leave some addresses unbacked; those become no-ops reading zero.
  assign in_range = ({1'b0, addr_reg} < (AW+1)'(DEPTH));

  always_comb begin
    post_next = '0;
    if (in_range) begin
      case (op_reg)
        OP_LOAD: post_next = wdata_reg;
        OP_SET:  post_next = '1;
        OP_CLR:  post_next = '0;
        default: post_next = bank_reg[addr_reg];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int j = 0; j < DEPTH; j++) bank_reg[j] <= '0;
    end else if (state_reg == EXEC && in_range) begin
      bank_reg[addr_reg] <= post_next;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_reg <= IDLE;
      op_reg    <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      win_reg   <= '0;
      gnt_reg   <= '0;
      ack_reg   <= '0;
      rdata_reg <= '0;
`ifndef DFF_SCHED_FIXED_PRIO_EN
      ptr_reg   <= IW'(NREQ-1);
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (found_next) begin
            op_reg    <= op_arr[win_next];
            addr_reg  <= addr_arr[win_next];
            wdata_reg <= wdata_arr[win_next];
            win_reg   <= win_next;
            gnt_reg   <= {{(NREQ-1){1'b0}}, 1'b1} << win_next;
            state_reg <= GRANT;
          end
        end
        GRANT: state_reg <= EXEC;
        EXEC: begin
          rdata_reg <= post_next;
          ack_reg   <= gnt_reg;
          state_reg <= RESP;
        end
        default: begin
          ack_reg   <= '0;
          gnt_reg   <= '0;
`ifndef DFF_SCHED_FIXED_PRIO_EN
          ptr_reg   <= win_reg;
`endif
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign gnt   = gnt_reg;
  assign ack   = ack_reg;
  assign rdata = rdata_reg;
  assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_dff_bank_sched.sv
// Bench for dff_bank_sched: a transaction-timeline model checked every cycle plus directed literal checks.
module tb_dff_bank_sched;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int NREQ  = 4;
  localparam int AW    = 3;

  localparam logic [1:0] LOAD = 2'b00, SET = 2'b01, CLR = 2'b10, READ = 2'b11;

  logic                   clk;
  logic                   Reset;
  logic [NREQ-1:0]        req;
  logic [2*NREQ-1:0]      op;
  logic [AW*NREQ-1:0]     addr;
  logic [WIDTH*NREQ-1:0]  wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        ack;
  logic [WIDTH-1:0]       rdata;
  logic                   busy;
  logic [WIDTH*DEPTH-1:0] q;

  dff_bank_sched #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
    .clk(clk), .Reset(Reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy), .q(q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each granted access occupies edges s..s+3; bank changes at s+2, next arbitration at s+4.
  logic [WIDTH-1:0] m_bank [DEPTH];
  logic [WIDTH-1:0] m_rdata;

  initial begin : model_and_compare
    logic             s_rst;
    logic [NREQ-1:0]  s_req;
    logic [2*NREQ-1:0] s_op;
    logic [AW*NREQ-1:0] s_addr;
    logic [WIDTH*NREQ-1:0] s_wdata;
    logic [1:0]       t_op;
    int               t_addr;
    logic [WIDTH-1:0] t_wdata;
    int e, s, free_at, win, m_ptr;
    bit active, init;
    logic [NREQ-1:0] exp_gnt, exp_ack;
    e = 0; s = 0; free_at = 0; win = 0; m_ptr = NREQ-1; active = 0; init = 0;
    t_op = 0; t_addr = 0; t_wdata = 0; m_rdata = 0;
    forever begin
      @(posedge clk);
      s_rst = Reset; s_req = req; s_op = op; s_addr = addr; s_wdata = wdata;
      e++;
      @(negedge clk);
      if (s_rst) begin
        for (int j = 0; j < DEPTH; j++) m_bank[j] = '0;
        m_rdata = '0; m_ptr = NREQ-1; active = 0; free_at = e + 1; init = 1;
      end else if (init) begin
        if (active && e == s + 2) begin
          case (t_op)
            LOAD:    m_bank[t_addr] = t_wdata;
            SET:     m_bank[t_addr] = '1;
            CLR:     m_bank[t_addr] = '0;
            default: ;
          endcase
          m_rdata = m_bank[t_addr];
        end
        if (active && e == s + 3) begin
          m_ptr = win; active = 0; free_at = e + 1;
        end
        if (!active && e >= free_at && s_req != '0) begin
          win = -1;
`ifdef DFF_SCHED_FIXED_PRIO_EN
          for (int i = NREQ-1; i >= 0; i--) if (s_req[i]) win = i;
`else
          for (int k = NREQ; k >= 1; k--) if (s_req[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
`endif
          active  = 1; s = e;
          t_op    = s_op[2*win +: 2];
          t_addr  = int'(s_addr[AW*win +: AW]);
          t_wdata = s_wdata[WIDTH*win +: WIDTH];
        end
      end
      if (init) begin
        exp_gnt = active ? (NREQ'(1) << win) : '0;
        exp_ack = (active && e == s + 2) ? (NREQ'(1) << win) : '0;
        check("gnt", WIDTH'(gnt), WIDTH'(exp_gnt));
        check("ack", WIDTH'(ack), WIDTH'(exp_ack));
        check("busy", WIDTH'(busy), WIDTH'(active));
        check("rdata", rdata, m_rdata);
        for (int j = 0; j < DEPTH; j++)
          check($sformatf("q[%0d]", j), q[WIDTH*j +: WIDTH], m_bank[j]);
      end
    end
  end

  task automatic drive(input int i, input logic [1:0] o, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    op[2*i +: 2] = o;
    addr[AW*i +: AW] = a;
    wdata[WIDTH*i +: WIDTH] = d;
    req[i] = 1'b1;
  endtask

  task automatic wait_ack(input int i);
    bit got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (ack[i]) got = 1;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL ack_timeout req%0d: got no ack, required one within 20 cycles", i);
    end
    req[i] = 1'b0;
  endtask

  task automatic wait_gnt(input int i);
    bit got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (gnt[i]) got = 1;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL gnt_timeout req%0d: got no gnt, required one within 20 cycles", i);
    end
  endtask

  task automatic wait_any(output int idx);
    idx = -1;
    for (int c = 0; c < 20 && idx < 0; c++) begin
      @(negedge clk);
      for (int i = NREQ-1; i >= 0; i--) if (ack[i]) idx = i;
    end
    n_checks++;
    if (idx < 0) begin
      n_fail++;
      $display("FAIL any_ack_timeout: got no ack, required one within 20 cycles");
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int got_idx;
    int exp_order [4] = '{0, 1, 2, 3};
    Reset = 1'b1; req = '0; op = '0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    check("rst_busy", WIDTH'(busy), 0);
    check("rst_gnt", WIDTH'(gnt), 0);
    check("rst_ack", WIDTH'(ack), 0);
    check("rst_rdata", rdata, 0);
    check("rst_q7", q[WIDTH*7 +: WIDTH], 0);

    drive(0, LOAD, 3'd3, 32'hA5A5_0F0F);
    wait_ack(0);
    #1;
    check("load_rdata", rdata, 32'hA5A5_0F0F);
    check("load_q3", q[WIDTH*3 +: WIDTH], 32'hA5A5_0F0F);
    check("model_q3", m_bank[3], 32'hA5A5_0F0F);

    drive(1, SET, 3'd5, 32'h0);
    wait_ack(1);
    drive(1, READ, 3'd5, 32'h0);
    wait_ack(1);
    #1;
    check("read_rdata", rdata, 32'hFFFF_FFFF);
    check("model_read", m_rdata, 32'hFFFF_FFFF);
    drive(1, CLR, 3'd5, 32'h0);
    wait_ack(1);
    #1;
    check("clr_q5", q[WIDTH*5 +: WIDTH], 32'h0);
    check("clr_rdata", rdata, 32'h0);

    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    for (int i = 0; i < NREQ; i++) drive(i, LOAD, AW'(i), 32'h1000_0000 + i);
    for (int k = 0; k < 4; k++) begin
      wait_any(got_idx);
      if (got_idx >= 0) req[got_idx] = 1'b0;
      check($sformatf("order[%0d]", k), WIDTH'(got_idx), WIDTH'(exp_order[k]));
    end
    #1;
    check("rr_q2", q[WIDTH*2 +: WIDTH], 32'h1000_0002);

`ifdef DFF_SCHED_FIXED_PRIO_EN
    drive(0, SET, 3'd0, 32'h0);
    drive(1, SET, 3'd1, 32'h0);
    wait_any(got_idx);
    check("fixed_first", WIDTH'(got_idx), 0);
    wait_any(got_idx);
    check("fixed_again", WIDTH'(got_idx), 0);
    req[0] = 1'b0;
    wait_any(got_idx);
    check("fixed_then1", WIDTH'(got_idx), 1);
    req[1] = 1'b0;
`endif

    drive(0, LOAD, 3'd2, 32'hDEAD_BEEF);
    wait_ack(0);
    drive(0, LOAD, 3'd2, 32'h5555_AAAA);
    wait_gnt(0);
    @(negedge clk);
    Reset = 1'b1;
    req = '0;
    @(negedge clk);
    Reset = 1'b0;
    check("abort_ack", WIDTH'(ack), 0);
    check("abort_busy", WIDTH'(busy), 0);
    check("abort_q2", q[WIDTH*2 +: WIDTH], 0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_ack", WIDTH'(ack), 0);
    end

    drive(2, LOAD, 3'd6, 32'h1234_5678);
    wait_gnt(2);
    wdata[WIDTH*2 +: WIDTH] = 32'h0;
    wait_ack(2);
    #1;
    check("frozen_q6", q[WIDTH*6 +: WIDTH], 32'h1234_5678);
    check("frozen_rdata", rdata, 32'h1234_5678);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
